adder_pipe: RTL

- Parametrised, pipelined successor to the team's combinational parametrised adder.
- Splits a WIDTH-bit unsigned add into CHUNKS carry-registered slices, one slice per pipeline stage.
- Valid/ready handshake with backpressure; full throughput of 1 add/cycle.
- Sits between operand producers (counters, DMA) and consumers needing WIDTH+1-bit sums at high clock rates.

---
 rtl/adder_pipe_pkg.sv | 26 ++
 rtl/adder_pipe_slice.sv | 30 +++
 rtl/adder_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared constants, slice-width helper and stage record for adder_pipe.
package adder_pipe_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_CHUNKS = 2;

  // Bits per pipeline slice. A zero slice count yields 0 so that the
  // top-level configuration check reports the error instead of a divide fault.
  function automatic int chunk_w(input int width, input int chunks);
    return (chunks > 0) ? width / chunks : 0;
  endfunction

  localparam int DEF_CHUNK_W = chunk_w(DEF_WIDTH, DEF_CHUNKS);

  // Contents of one pipeline stage at the default size: the stage valid, its
  // carry out, the sum slices finished so far, and the operand slices that
  // later stages have not consumed yet.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] sum_lo;
    logic [DEF_WIDTH-1:0] a_hi;
    logic [DEF_WIDTH-1:0] b_hi;
  } stage_t;

endpackage

// File: rtl/adder_pipe_slice.sv
// One CW-bit adder slice. The sum, carry and valid are registered behind a
// shared enable.
module adder_pipe_slice #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          vld_in,
  input  logic          c_in,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  output logic          vld,
  output logic [CW-1:0] s,
  output logic          c
);

  // Add and register this slice, holding while the pipe is stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= 1'b0;
      s   <= '0;
      c   <= 1'b0;
    end else if (en) begin
      vld    <= vld_in;
      {c, s} <= {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, c_in};
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit unsigned adder built from CHUNKS carry-registered
// slices, with one slice per stage and a valid/ready handshake.
// Optional feature: define ADDER_PIPE_SUB_EN to add a 'sub' input that selects
// a - b (a + ~b + 1). In that mode sum[WIDTH]=1 means there was no borrow.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CHUNKS = DEF_CHUNKS
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int CW = chunk_w(WIDTH, CHUNKS);

  if (WIDTH < 1 || CHUNKS < 1 || (WIDTH % CHUNKS) != 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be >= 1 and a multiple of CHUNKS");
  end

  // vld_pipe[0] and c_pipe[0] are the inputs to the pipe.
  // vld_pipe[k+1] and c_pipe[k+1] are the registered outputs of stage k.
  logic [CHUNKS:0] vld_pipe;
  logic [CHUNKS:0] c_pipe;
  logic            adv;
  logic            sub_in;

`ifdef ADDER_PIPE_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // The enable is global, so every stage advances together. Bubbles keep
  // their position and are never squeezed out.
  assign adv         = !out_valid | out_ready;
  assign in_ready    = adv;
  assign vld_pipe[0] = in_valid;
  // Subtraction forces a carry-in of 1 and ignores cin.
  assign c_pipe[0]   = sub_in ? 1'b1 : cin;

  for (genvar k = 0; k < CHUNKS; k++) begin : g_st
    logic [WIDTH-k*CW-1:0] a_cur, b_cur;
    logic                  sub_cur;
    logic [CW-1:0]         s_k;
    logic [(k+1)*CW-1:0]   sum_lo;

    if (k == 0) begin : g_head
      assign a_cur   = a;
      assign b_cur   = b;
      assign sub_cur = sub_in;
    end else begin : g_tail
      assign a_cur   = g_st[k-1].g_skew.a_hi;
      assign b_cur   = g_st[k-1].g_skew.b_hi;
      assign sub_cur = g_st[k-1].g_skew.sub_q;
    end

    adder_pipe_slice #(.CW(CW)) u_slice (
      .clk    (clk),
      .rstn   (rstn),
      .en     (adv),
      .vld_in (vld_pipe[k]),
      .c_in   (c_pipe[k]),
      .a      (a_cur[CW-1:0]),
      .b      (b_cur[CW-1:0] ^ {CW{sub_cur}}),
      .vld    (vld_pipe[k+1]),
      .s      (s_k),
      .c      (c_pipe[k+1])
    );

    // Skew buffer: carry the unconsumed upper operand slices and the sub
    // flag forward to the stages that will use them.
    if (k < CHUNKS-1) begin : g_skew
      logic [WIDTH-(k+1)*CW-1:0] a_hi, b_hi;
      logic                      sub_q;
      // Register the operand slices still pending for later stages.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_hi  <= '0;
          b_hi  <= '0;
          sub_q <= 1'b0;
        end else if (adv) begin
          a_hi  <= a_cur[WIDTH-k*CW-1:CW];
          b_hi  <= b_cur[WIDTH-k*CW-1:CW];
          sub_q <= sub_cur;
        end
      end
    end

    // Lower sum slices finished by earlier stages travel alongside the
    // slice that is currently being computed.
    if (k > 0) begin : g_lo
      logic [k*CW-1:0] lo_q;
      // Register the completed lower sum slices.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    lo_q <= '0;
        else if (adv) lo_q <= g_st[k-1].sum_lo;
      end
      assign sum_lo = {s_k, lo_q};
    end else begin : g_lo0
      assign sum_lo = s_k;
    end
  end

  assign out_valid = vld_pipe[CHUNKS];
  assign sum       = {c_pipe[CHUNKS], g_st[CHUNKS-1].sum_lo};

endmodule
